// File: rtl/pixel_frame_buffer.sv
// Single-port frame store of CH*N*M channel words with valid/ready capture and playback streams.
// Optional zero-fill command is compiled in with PIXEL_FRAME_BUFFER_CLEAR_EN.
module pixel_frame_buffer #(
    parameter  int DW    = 8,
    parameter  int N     = 450,
    parameter  int M     = 450,
    parameter  int CH    = 3,
    localparam int DEPTH = CH * N * M,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = (CH > 1) ? $clog2(CH) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          fb_enable,
    input  logic          rw,
    input  logic          clear,
    input  logic [DW-1:0] in_data,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [DW-1:0] out_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [CW-1:0] out_ch,
    output logic          out_last,
    output logic          busy,
    output logic          fb_done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WRITE,
        S_READ
`ifdef PIXEL_FRAME_BUFFER_CLEAR_EN
        , S_CLEAR
`endif
    } state_t;

    logic [DW-1:0] mem [DEPTH];

    state_t        state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [CW-1:0] ch_q, ch_d;
    logic          fetched_q, fetched_d;
    logic          out_valid_q, out_valid_d;
    logic [DW-1:0] out_data_q, out_data_d;
    logic [CW-1:0] out_ch_q, out_ch_d;
    logic          out_last_q, out_last_d;
    logic          in_ready_q, in_ready_d;
    logic          busy_q, busy_d;
    logic          fb_done_q, fb_done_d;
    logic          mem_we;
    logic [DW-1:0] mem_wdata;
    logic          last_addr;

`ifndef PIXEL_FRAME_BUFFER_CLEAR_EN
    logic unused_clear;
    assign unused_clear = clear;
`endif

    assign last_addr = (addr_q == AW'(DEPTH - 1));

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        ch_d        = ch_q;
        fetched_d   = fetched_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        out_last_d  = out_last_q;
        fb_done_d   = 1'b0;
        mem_we      = 1'b0;
        mem_wdata   = in_data;

        case (state_q)
            S_IDLE: begin
                addr_d    = '0;
                ch_d      = '0;
                fetched_d = 1'b0;
                if (fb_enable) begin
`ifdef PIXEL_FRAME_BUFFER_CLEAR_EN
                    if (clear)   state_d = S_CLEAR;
                    else if (rw) state_d = S_WRITE;
                    else         state_d = S_READ;
`else
                    state_d = rw ? S_WRITE : S_READ;
`endif
                end
            end
            S_WRITE: begin
                if (in_valid) begin
                    mem_we = 1'b1;
                    addr_d = addr_q + AW'(1);
                    if (last_addr) begin
                        state_d   = S_IDLE;
                        fb_done_d = 1'b1;
                    end
                end
            end
            S_READ: begin
                if (out_valid_q && out_ready && out_last_q) begin
                    state_d     = S_IDLE;
                    fb_done_d   = 1'b1;
                    out_valid_d = 1'b0;
                end else if ((!out_valid_q || out_ready) && !fetched_q) begin
                    out_valid_d = 1'b1;
                    out_data_d  = mem[addr_q];
                    out_ch_d    = ch_q;
                    out_last_d  = last_addr;
                    ch_d        = (ch_q == CW'(CH - 1)) ? '0 : ch_q + CW'(1);
                    // Address parks on the last word; IDLE rewinds it.
                    if (last_addr) fetched_d = 1'b1;
                    else           addr_d    = addr_q + AW'(1);
                end else if (out_ready) begin
                    out_valid_d = 1'b0;
                end
            end
`ifdef PIXEL_FRAME_BUFFER_CLEAR_EN
            S_CLEAR: begin
                mem_we    = 1'b1;
                mem_wdata = '0;
                addr_d    = addr_q + AW'(1);
                if (last_addr) begin
                    state_d   = S_IDLE;
                    fb_done_d = 1'b1;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase

        // Abort: a word already handshaken this cycle is still stored.
        if (state_q != S_IDLE && !fb_enable) begin
            state_d     = S_IDLE;
            fb_done_d   = 1'b0;
            out_valid_d = 1'b0;
        end

        in_ready_d = (state_d == S_WRITE);
        busy_d     = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem[addr_q] <= mem_wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            ch_q        <= '0;
            fetched_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
            out_last_q  <= 1'b0;
            in_ready_q  <= 1'b0;
            busy_q      <= 1'b0;
            fb_done_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            ch_q        <= ch_d;
            fetched_q   <= fetched_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            out_last_q  <= out_last_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
            fb_done_q   <= fb_done_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_ch    = out_ch_q;
    assign out_last  = out_last_q;
    assign busy      = busy_q;
    assign fb_done   = fb_done_q;

endmodule

// File: tb/tb_pixel_frame_buffer.sv
// Scoreboard bench for pixel_frame_buffer on a 2x2x3 frame; monitor pops expected words on each output handshake.
module tb_pixel_frame_buffer;
    localparam int DEPTH = 12;

    logic       clk = 0, rst_n = 0;
    logic       fb_enable = 0, rw = 0, clear = 0;
    logic [7:0] in_data = 0;
    logic       in_valid = 0, in_ready;
    logic [7:0] out_data;
    logic       out_valid, out_ready = 0;
    logic [1:0] out_ch;
    logic       out_last, busy, fb_done;

    pixel_frame_buffer #(.DW(8), .N(2), .M(2), .CH(3)) dut (
        .clk(clk), .rst_n(rst_n), .fb_enable(fb_enable), .rw(rw), .clear(clear),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_ch(out_ch), .out_last(out_last), .busy(busy), .fb_done(fb_done));

    always #5 clk = ~clk;

    typedef struct { logic [7:0] d; logic [1:0] ch; logic last; } exp_t;
    exp_t       exp_q[$];
    logic [7:0] model[DEPTH];
    int         checks = 0, errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: scoreboard pops on each handshake, and held outputs must not move while stalled.
    logic       prev_stall = 0;
    exp_t       prev;
    always @(negedge clk) begin
        if (!rst_n) prev_stall = 0;
        else begin
            if (prev_stall && out_valid) begin
                chk("stall_data", out_data, prev.d);
                chk("stall_ch", out_ch, prev.ch);
                chk("stall_last", out_last, prev.last);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) chk("unexpected_out", 1, 0);
                else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("out_data", out_data, e.d);
                    chk("out_ch", out_ch, e.ch);
                    chk("out_last", out_last, e.last);
                end
            end
            prev_stall = out_valid && !out_ready;
            prev.d = out_data; prev.ch = out_ch; prev.last = out_last;
        end
    end

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_in_ready"}, in_ready, 0);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_fb_done"}, fb_done, 0);
        chk({tag, "_out_data"}, out_data, 0);
        chk({tag, "_out_ch"}, out_ch, 0);
        chk({tag, "_out_last"}, out_last, 0);
    endtask

    task automatic do_write(input bit seq, input bit gaps);
        int i = 0, cycles = 0;
        @(posedge clk); #1; fb_enable = 1; rw = 1; clear = 0;
        @(posedge clk); #1;
        chk("wr_busy", busy, 1);
        while (i < DEPTH && cycles < 100) begin
            in_valid = gaps ? (cycles % 2 == 0) : 1'b1;
            in_data  = seq ? 8'(i + 1) : 8'($urandom_range(1, 255));
            chk("in_ready", in_ready, 1);
            @(posedge clk); #1;
            cycles++;
            if (in_valid) begin model[i] = in_data; i++; end
        end
        fb_enable = 0; in_valid = 0;
        chk("wr_cycles", cycles, gaps ? 23 : 12);
        chk("wr_done", fb_done, 1);
        chk("wr_done_busy", busy, 0);
        @(posedge clk); #1;
        chk("wr_done_width", fb_done, 0);
    endtask

    // mode 0: always ready, 1: 5-cycle stall at word 4, 2: random ready
    task automatic do_read(input int mode, input int abort_at);
        int hs = 0, stall = 0;
        bit hs_now, fin = 0;
        @(posedge clk); #1; fb_enable = 1; rw = 0; clear = 0;
        for (int k = 0; k < DEPTH; k++) begin
            exp_t e;
            e.d = model[k]; e.ch = 2'(k % 3); e.last = (k == DEPTH - 1);
            exp_q.push_back(e);
        end
        @(posedge clk); #1;
        chk("rd_busy", busy, 1);
        chk("rd_first_invalid", out_valid, 0);
        for (int cyc = 0; cyc < 200 && !fin; cyc++) begin
            if (mode == 0) out_ready = 1;
            else if (mode == 1) begin
                if (hs == 4 && stall < 5) begin out_ready = 0; stall++; end
                else out_ready = 1;
            end else out_ready = ($urandom_range(0, 3) != 0);
            hs_now = out_valid && out_ready;
            @(posedge clk); #1;
            if (cyc == 0) chk("rd_latency", out_valid, 1);
            if (hs_now) hs++;
            if (abort_at != 0 && hs == abort_at) begin
                fb_enable = 0; out_ready = 0;
                @(posedge clk); #1;
                chk("abort_valid", out_valid, 0);
                chk("abort_busy", busy, 0);
                chk("abort_no_done", fb_done, 0);
                exp_q.delete();
                fin = 1;
            end else if (hs == DEPTH) begin
                fb_enable = 0; out_ready = 0;
                chk("rd_done", fb_done, 1);
                chk("rd_done_busy", busy, 0);
                chk("rd_done_valid", out_valid, 0);
                chk("rd_q_empty", exp_q.size(), 0);
                @(posedge clk); #1;
                chk("rd_done_width", fb_done, 0);
                fin = 1;
            end
        end
        if (!fin) begin
            chk("rd_timeout", 1, 0);
            fb_enable = 0; out_ready = 0; exp_q.delete();
        end
    endtask

    initial begin
        #3;
        check_idle_outputs("reset");
        repeat (2) @(posedge clk);
        #1; rst_n = 1;

        do_write(1, 0);
        do_read(0, 0);
        do_write(0, 1);
        do_read(1, 0);
        do_read(2, 0);
        do_read(0, 5);
        do_read(0, 0);

`ifdef PIXEL_FRAME_BUFFER_CLEAR_EN
        begin
            int n = 0;
            do_write(0, 0);
            @(posedge clk); #1; fb_enable = 1; clear = 1; rw = 1;
            @(posedge clk); #1;
            while (busy && n < 100) begin n++; @(posedge clk); #1; end
            fb_enable = 0; clear = 0;
            chk("clr_cycles", n, DEPTH);
            chk("clr_done", fb_done, 1);
            for (int k = 0; k < DEPTH; k++) model[k] = 8'h00;
            do_read(0, 0);
        end
`endif

        // Reset in the middle of a write: outputs drop immediately, memory keeps what was written.
        @(posedge clk); #1; fb_enable = 1; rw = 1;
        @(posedge clk); #1;
        for (int k = 0; k < 5; k++) begin
            in_valid = 1; in_data = 8'($urandom_range(1, 255));
            @(posedge clk); #1;
            model[k] = in_data;
        end
        rst_n = 0; #1;
        check_idle_outputs("midreset");
        in_valid = 0; fb_enable = 0;
        @(posedge clk); #1; rst_n = 1;
        do_write(0, 0);
        do_read(2, 0);

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
        $fatal(1);
    end
endmodule

// File: doc/pixel_frame_buffer.md
# pixel_frame_buffer

Parametrised single-port frame store for interleaved multi-channel pixel data. It sits between the camera capture path and the grayscaling stage, and is sequenced by the controller. It generalises the fixed 8-bit, 3-channel RGB store in three ways: configurable width, depth and channel count; a valid/ready handshake on both data streams instead of a fixed pause pattern; and mid-operation abort.

## Interface
- `DW`, 8, pixel channel word width in bits
- `N`, 450, frame rows
- `M`, 450, frame columns
- `CH`, 3, channels per pixel. The block stores `DEPTH = CH*N*M` words.
- `AW`, `$clog2(DEPTH)`, address width (derived; never overridden)
- `CW`, `$clog2(CH)` (minimum 1), channel index width (derived)

Ports:
- `clk` in 1 — single clock; all logic on rising edge
- `rst_n` in 1 — asynchronous, active-low reset
- `fb_enable` in 1 — controller command strobe/hold
- `rw` in 1 — 1 = write (capture), 0 = read (playback)
- `clear` in 1 — request zero-fill of the whole store
- `in_data` in DW — camera word
- `in_valid` in 1 — `in_data` is valid
- `in_ready` out 1 — block accepts `in_data` this cycle
- `out_data` out DW — word to grayscaler
- `out_valid` out 1 — `out_data` is valid
- `out_ready` in 1 — grayscaler accepts `out_data`
- `out_ch` out CW — channel index of `out_data` (0..CH-1)
- `out_last` out 1 — `out_data` is word `DEPTH-1`
- `busy` out 1 — FSM is not in IDLE
- `fb_done` out 1 — one-cycle completion pulse

## Operation
- FSM states are IDLE, WRITE, READ, CLEAR.
- **IDLE:** address = 0, channel = 0. When `fb_enable=1`, the next state is selected by priority:
  - CLEAR, if `clear=1`
  - else WRITE, if `rw=1`
  - else READ
- **WRITE:**
  - `in_ready=1`.
  - Each cycle with `in_valid=1` writes `in_data` to `mem[addr]` and increments addr.
  - Cycles with `in_valid=0` write nothing and hold addr.
  - The write at addr `DEPTH-1` returns the FSM to IDLE and pulses `fb_done`.
- **READ:**
  - Registered output stage.
  - Fetch `mem[addr]` into `out_data` whenever (`out_valid=0` or `out_ready=1`) and unfetched words remain; addr increments on each fetch.
  - `out_ch` and `out_last` are registered alongside the data.
  - `out_data`, `out_ch` and `out_last` stay stable while `out_valid=1` and `out_ready=0`.
  - The handshake on the last word returns the FSM to IDLE and pulses `fb_done`.
- **CLEAR:** writes 0 to one address per cycle, from 0 up to `DEPTH-1`, then returns to IDLE and pulses `fb_done`.
- **Abort:**
  - `fb_enable=0` in any non-IDLE state forces IDLE on the next edge.
  - No `fb_done` pulse; `out_valid` is cleared; memory already written is kept.
- **Channel counter:** `out_ch` wraps `CH-1 → 0`; the address wraps only on return to IDLE.
- **Ignored inputs:** `rw` and `clear` are sampled only in IDLE; changes during an operation have no effect.
- **Memory contents:** not reset by `rst_n`.

## Timing
- **Reset values:** `in_ready=0`, `out_valid=0`, `out_data=0`, `out_ch=0`, `out_last=0`, `busy=0`, `fb_done=0`, state IDLE.
- **Command latency:** a command sampled in IDLE at edge T gives `busy=1` (and `in_ready=1` for WRITE) after T.
- **Write throughput:** the first write is accepted at edge T+1. Zero bubbles: DEPTH words take DEPTH cycles when `in_valid` is held high.
- **Read latency:** the first fetch happens at edge T+1, so `out_valid=1` after T+1. Read throughput is 1 word/cycle with `out_ready` held high.
- **Clear duration:** exactly DEPTH cycles in CLEAR.
- **Done pulse:** `fb_done` is high for exactly the one cycle following the final write, final output handshake, or final clear write. `busy=0` in that same cycle.
- **Back-to-back commands:** a new command may be accepted in the cycle `fb_done` is high, if `fb_enable=1`.
- **Reset mid-operation:** asynchronous return to IDLE with all outputs at their reset values.

## Configuration
- **Macro:** `PIXEL_FRAME_BUFFER_CLEAR_EN`
- **Defined:** the CLEAR state and zero-fill behave as described above.
- **Undefined:**
  - No CLEAR state and no zero-fill logic.
  - The `clear` input is ignored, and selection in IDLE is by `rw` alone.

## Test plan
- **Write then read:** `N=2`, `M=2`, `CH=3`. Write words 0x01..0x0C with `in_valid` held high → `fb_done` pulses after the 12th write. Then read with `out_ready=1` → 12 consecutive words 0x01..0x0C, `out_ch` sequence 0,1,2 repeated, `out_last` only on 0x0C, `fb_done` one cycle after.
- **Write gaps:** `in_valid` toggling 1,0,1,0 during WRITE → only the valid cycles are stored. A readback matches, and the write phase takes 23 cycles for 12 words.
- **Read backpressure:** `out_ready` low for 5 cycles at word 4 → `out_data`, `out_ch` and `out_last` are held stable and no word is skipped or duplicated.
- **Clear** (macro defined): after writing nonzero data, issue clear → `busy` high for 12 cycles, `fb_done` pulses, and readback returns all zeros.
- **Abort:** drop `fb_enable` after the 5th read handshake → IDLE next cycle, `out_valid=0`, no `fb_done`. A fresh read restarts at word 0.
- **Reset:** assert `rst_n=0` mid-WRITE → all outputs 0 immediately; after release, a write+read of 12 words passes.
